// File: rtl/inv_search_2.sv
// -----------------------------------------------------------------------------
// inv_search_2
//   Inverse solver for the 3-bit gate function F(a,b) -> y. After a target y is
//   accepted, the block walks all 64 (a,b) candidates in ascending order, one
//   per clock, and reports the first pair that produces y. If no pair produces
//   y, it reports found=0 with a/b = 0.
//
//   Candidate index: a = idx[2:0], b = idx[5:3].
//
//   Optional feature (macro INV_SEARCH_ABORT_EN):
//     adds input i_abort. When i_abort is high in SEARCH, the block returns to
//     IDLE without raising done_valid and leaves the result outputs as they
//     were. With the macro undefined there is no abort port.
//
// Ports
//   i_clk          clock, all state changes on rising edge
//   i_rst          synchronous active-high reset
//   i_start_valid  request to solve for i_target
//   o_start_ready  block can accept a request (IDLE and not in reset)
//   i_target       required y, sampled only when a start is accepted
//   o_done_valid   result available (DONE)
//   i_done_ready   consumer accepts result
//   i_abort        (INV_SEARCH_ABORT_EN only) abandon the current search
//   o_found        1 = o_a_out/o_b_out are a solution, 0 = target unreachable
//   o_a_out        solution a
//   o_b_out        solution b
//   o_busy         high while searching
//
// state  | meaning
// IDLE   | waiting for a start request
// SEARCH | evaluating candidate r_idx this cycle
// DONE   | result held until the consumer accepts it
// -----------------------------------------------------------------------------
module inv_search_2 #(
    parameter int W     = 3,        // F is only defined for 3-bit operands
    parameter int IDX_W = 2 * W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start_valid,
    output logic         o_start_ready,
    input  logic [W-1:0] i_target,
    output logic         o_done_valid,
    input  logic         i_done_ready,
`ifdef INV_SEARCH_ABORT_EN
    input  logic         i_abort,
`endif
    output logic         o_found,
    output logic [W-1:0] o_a_out,
    output logic [W-1:0] o_b_out,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_target;
    logic             r_found;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;

    logic             w_abort;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_y;
    logic             w_match;
    logic             w_last;

`ifdef INV_SEARCH_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Forward function evaluated on the current candidate
    always_comb begin
        logic w0, w1, w2, w3, w4, w5;
        w_a = r_idx[W-1:0];
        w_b = r_idx[IDX_W-1:W];
        w0  = w_a[0] | w_b[2];
        w2  = w_a[2] & w_b[2];
        w1  = w0 & w_b[0];
        w3  = w2 | w_b[1];
        w4  = w_a[1] | w_b[0];
        w5  = w4 & ~w_b[2];
        w_y = {w3 | w5, (w0 ^ w2) & w3, w1 ^ w2};
    end

    assign w_match = (w_y == r_target);
    assign w_last  = (r_idx == IDX_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start_valid) w_next_state = SEARCH;
            end
            SEARCH: begin
                // abort takes priority over a match in the same cycle
                if (w_abort)                w_next_state = IDLE;
                else if (w_match || w_last) w_next_state = DONE;
            end
            DONE: begin
                if (i_done_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_target <= '0;
            r_found  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (i_start_valid) begin
                        r_target <= i_target;
                        r_idx    <= '0;
                    end
                end
                SEARCH: begin
                    if (!w_abort) begin
                        if (w_match) begin
                            r_found <= 1'b1;
                            r_a     <= w_a;
                            r_b     <= w_b;
                        end else if (w_last) begin
                            r_found <= 1'b0;
                            r_a     <= '0;
                            r_b     <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // start_ready is masked by reset so nothing can be accepted while held
    assign o_start_ready = (r_state == IDLE) && !i_rst;
    assign o_done_valid  = (r_state == DONE);
    assign o_busy        = (r_state == SEARCH);
    assign o_found       = r_found;
    assign o_a_out       = r_a;
    assign o_b_out       = r_b;

endmodule

// File: tb/tb_inv_search_2.sv
module tb_inv_search_2;

    logic       clk;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [2:0] target;
    logic       done_valid;
    logic       done_ready;
    logic       found;
    logic [2:0] a_out;
    logic [2:0] b_out;
    logic       busy;
`ifdef INV_SEARCH_ABORT_EN
    logic       abort;
`endif

    int errors = 0;
    int checks = 0;

    inv_search_2 dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_target      (target),
        .o_done_valid  (done_valid),
        .i_done_ready  (done_ready),
`ifdef INV_SEARCH_ABORT_EN
        .i_abort       (abort),
`endif
        .o_found       (found),
        .o_a_out       (a_out),
        .o_b_out       (b_out),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] f_ref(input logic [2:0] a, input logic [2:0] b);
        logic w0, w1, w2, w3, w4, w5;
        w0 = a[0] | b[2];
        w2 = a[2] & b[2];
        w1 = w0 & b[0];
        w3 = w2 | b[1];
        w4 = a[1] | b[0];
        w5 = w4 & ~b[2];
        return {w3 | w5, (w0 ^ w2) & w3, w1 ^ w2};
    endfunction

    // Drives a start at a falling edge; the next rising edge is the end of cycle T.
    // lat is the number of cycles after T at which done_valid is first seen
    // (done in cycle T+lat), or -1 if the bound expires.
    task automatic start_and_wait(input logic [2:0] tgt, input logic [2:0] mid_tgt,
                                  output int lat);
        int cyc;
        @(negedge clk);
        start_valid = 1'b1;
        target      = tgt;
        @(posedge clk);
        lat = -1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start_valid = 1'b0;
                target      = mid_tgt;
            end
            if (done_valid) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic release_result();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL reset_start_ready got=%b exp=0", start_ready); end
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({found, a_out, b_out} !== 7'd0) begin errors++; $display("FAIL reset_outputs got=%b/%0d/%0d exp=0/0/0", found, a_out, b_out); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", start_ready); end
    endtask

    task automatic test_first_candidate();
        int lat;
        start_and_wait(3'b000, 3'b000, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL t000_latency got=%0d exp=2", lat); end
        checks++; if ({found, a_out, b_out} !== {1'b1, 3'd0, 3'd0}) begin errors++; $display("FAIL t000_result got=%b/%0d/%0d exp=1/0/0", found, a_out, b_out); end
        release_result();
        checks++; if (done_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL t000_handshake got dv=%b sr=%b exp dv=0 sr=1", done_valid, start_ready); end
    endtask

    task automatic test_target_change();
        int lat;
        start_and_wait(3'b100, 3'b111, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL t100_latency got=%0d exp=4", lat); end
        checks++; if ({found, a_out, b_out} !== {1'b1, 3'd2, 3'd0}) begin errors++; $display("FAIL t100_result got=%b/%0d/%0d exp=1/2/0", found, a_out, b_out); end
        release_result();
    endtask

    task automatic test_unreachable();
        int lat;
        logic [2:0] tg [2];
        tg[0] = 3'b010;
        tg[1] = 3'b011;
        for (int i = 0; i < 2; i++) begin
            start_and_wait(tg[i], 3'b000, lat);
            checks++; if (lat !== 65) begin errors++; $display("FAIL unreach_%b_latency got=%0d exp=65", tg[i], lat); end
            checks++; if ({found, a_out, b_out} !== 7'd0) begin errors++; $display("FAIL unreach_%b_result got=%b/%0d/%0d exp=0/0/0", tg[i], found, a_out, b_out); end
            release_result();
        end
    endtask

    task automatic test_hold_done();
        int lat;
        start_and_wait(3'b001, 3'b110, lat);
        checks++; if (lat !== 42) begin errors++; $display("FAIL t001_latency got=%0d exp=42", lat); end
        checks++; if ({found, a_out, b_out} !== {1'b1, 3'd0, 3'd5}) begin errors++; $display("FAIL t001_result got=%b/%0d/%0d exp=1/0/5", found, a_out, b_out); end
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            target      = 3'b000;
            @(negedge clk);
            checks++;
            if (done_valid !== 1'b1 || start_ready !== 1'b0 || {found, a_out, b_out} !== {1'b1, 3'd0, 3'd5}) begin
                errors++;
                $display("FAIL hold_stable[%0d] got dv=%b sr=%b res=%b/%0d/%0d exp dv=1 sr=0 res=1/0/5", i, done_valid, start_ready, found, a_out, b_out);
            end
        end
        start_valid = 1'b0;
        release_result();
        checks++; if (done_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL hold_release got dv=%b sr=%b exp dv=0 sr=1", done_valid, start_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_queue got busy=%b exp=0", busy); end
    endtask

    task automatic test_mid_reset();
        int lat;
        @(negedge clk);
        start_valid = 1'b1;
        target      = 3'b001;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start_valid = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_valid !== 1'b0 || start_ready !== 1'b0 || {found, a_out, b_out} !== 7'd0) begin
            errors++;
            $display("FAIL midrst_state got busy=%b dv=%b sr=%b res=%b/%0d/%0d exp all 0", busy, done_valid, start_ready, found, a_out, b_out);
        end
        rst = 1'b0;
        start_and_wait(3'b000, 3'b000, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_restart_latency got=%0d exp=2", lat); end
        checks++; if ({found, a_out, b_out} !== {1'b1, 3'd0, 3'd0}) begin errors++; $display("FAIL midrst_restart_result got=%b/%0d/%0d exp=1/0/0", found, a_out, b_out); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        done_ready = 1'b1;
        start_and_wait(3'b000, 3'b000, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=2", lat); end
        @(negedge clk);
        checks++; if (done_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL b2b_same_cycle_ack got dv=%b sr=%b exp dv=0 sr=1", done_valid, start_ready); end
        start_and_wait(3'b100, 3'b100, lat);
        checks++; if (lat !== 4 || {found, a_out, b_out} !== {1'b1, 3'd2, 3'd0}) begin errors++; $display("FAIL b2b_second got lat=%0d res=%b/%0d/%0d exp lat=4 res=1/2/0", lat, found, a_out, b_out); end
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_all_targets();
        int lat;
        int exp_lat;
        logic exp_found;
        logic [5:0] exp_idx;
        for (int t = 0; t < 8; t++) begin
            exp_found = 1'b0;
            exp_idx   = '0;
            for (int k = 0; k < 64; k++) begin
                logic [5:0] kk;
                kk = k[5:0];
                if (!exp_found && f_ref(kk[2:0], kk[5:3]) == t[2:0]) begin
                    exp_found = 1'b1;
                    exp_idx   = kk;
                end
            end
            exp_lat = exp_found ? (int'(exp_idx) + 2) : 65;
            if (!exp_found) exp_idx = '0;
            start_and_wait(t[2:0], ~t[2:0], lat);
            checks++;
            if (lat !== exp_lat || {found, a_out, b_out} !== {exp_found, exp_idx[2:0], exp_idx[5:3]}) begin
                errors++;
                $display("FAIL all_t%0d got lat=%0d res=%b/%0d/%0d exp lat=%0d res=%b/%0d/%0d",
                         t, lat, found, a_out, b_out, exp_lat, exp_found, exp_idx[2:0], exp_idx[5:3]);
            end
            release_result();
        end
    endtask

`ifdef INV_SEARCH_ABORT_EN
    task automatic test_abort();
        logic [6:0] prev;
        int seen;
        prev = {found, a_out, b_out};
        @(negedge clk);
        start_valid = 1'b1;
        target      = 3'b001;
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start_valid = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1 || done_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b sr=%b dv=%b exp 0/1/0", busy, start_ready, done_valid); end
        checks++; if ({found, a_out, b_out} !== prev) begin errors++; $display("FAIL abort_outputs_kept got=%b exp=%b", {found, a_out, b_out}, prev); end
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        target      = 3'b000;
        done_ready  = 1'b0;
`ifdef INV_SEARCH_ABORT_EN
        abort       = 1'b0;
`endif
        test_reset();
        test_first_candidate();
        test_target_change();
        test_unreachable();
        test_hold_done();
        test_mid_reset();
        test_back_to_back();
        test_all_targets();
`ifdef INV_SEARCH_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
